// File: rtl/synth_spi_cfg_if.sv
// Bundle of SPI pins, the datapath apply tick and the live config outputs.
// No logic of its own; it groups the signals that cross the block boundary.
// Host/bench drives through the master modport, and the config controller uses the slave modport.
interface synth_spi_cfg_if #(
  parameter int NUM_REGS = 8
);
  logic                  spi_clk;
  logic                  spi_mosi;
  logic                  spi_nss;
  logic                  apply_strb;
  logic [NUM_REGS*8-1:0] cfg_regs;
  logic                  cfg_upd;
  logic                  frame_err;
  logic                  busy;

  modport master (
    output spi_clk, spi_mosi, spi_nss, apply_strb,
    input  cfg_regs, cfg_upd, frame_err, busy
  );

  modport slave (
    input  spi_clk, spi_mosi, spi_nss, apply_strb,
    output cfg_regs, cfg_upd, frame_err, busy
  );
endinterface

// File: rtl/synth_spi_cfg.sv
// Write-only SPI slave: deframes 16-bit writes into a shadow file, applied atomically on apply_strb.
// Latency: pin edge -> FSM action SYNC_STAGES+1 clk; apply_strb -> cfg_regs next edge, cfg_upd with it.
// No backpressure: SPI is free-running and extra bits are dropped; un-applied writes merge in the shadow.
module synth_spi_cfg #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 8
) (
  input logic            clk,
  input logic            rstn,
  synth_spi_cfg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_nss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_hist;
  logic                   r_nss_hist;

  logic [4:0]            r_cnt;
  logic [15:0]           r_shift;
  logic [NUM_REGS*8-1:0] r_shadow;
  logic [NUM_REGS*8-1:0] r_cfg;
  logic                  r_pending;
  logic                  r_cfg_upd;
  logic                  r_frame_err;

  logic w_sck_rise;
  logic w_nss_fall;
  logic w_nss_rise;
  logic w_mosi;
  logic w_clr;
  logic w_shift_en;
  logic w_err;
  logic w_frame_end;
  logic w_addr_ok;
  logic w_commit;
  logic w_apply;

  // Synchronise the asynchronous SPI pins and keep one history flop for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sck_sync  <= '1;
      r_nss_sync  <= '1;
      r_mosi_sync <= '0;
      r_sck_hist  <= 1'b1;
      r_nss_hist  <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_clk};
      r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], bus.spi_nss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_sck_hist  <= r_sck_sync[SYNC_STAGES-1];
      r_nss_hist  <= r_nss_sync[SYNC_STAGES-1];
    end
  end

  // MOSI goes through the same depth as SCK, so it lines up with the detected rising edge
  assign w_sck_rise = r_sck_sync[SYNC_STAGES-1] & ~r_sck_hist;
  assign w_nss_fall = ~r_nss_sync[SYNC_STAGES-1] & r_nss_hist;
  assign w_nss_rise = r_nss_sync[SYNC_STAGES-1] & ~r_nss_hist;
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];

  // Frame state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes for the deframer
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift_en  = 1'b0;
    w_err       = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_nss_fall) begin
          w_state_nxt = ST_SHIFT;
          w_clr       = 1'b1;
        end
      end
      ST_SHIFT: begin
        // Chip select dropping out wins over a coincident clock edge: the frame is short
        if (w_nss_rise) begin
          w_state_nxt = ST_IDLE;
          w_err       = 1'b1;
        end else if (w_sck_rise) begin
          w_shift_en = 1'b1;
          if (r_cnt == 5'd15) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Trailing clocks are ignored; only the end of select matters here
        if (w_nss_rise) begin
          w_state_nxt = ST_IDLE;
          w_frame_end = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Writes outside the implemented register range are silently dropped
  assign w_addr_ok = ({1'b0, r_shift[14:8]} < 8'(NUM_REGS));
  assign w_commit  = w_frame_end & r_shift[15] & w_addr_ok;
  assign w_apply   = bus.apply_strb & r_pending;

  // Bit counter and shift register for the frame being received
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_clr) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_cnt   <= r_cnt + 5'd1;
      r_shift <= {r_shift[14:0], w_mosi};
    end
  end

  // Shadow file: a completed write frame lands here until the next apply
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shadow <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_commit && (r_shift[14:8] == 7'(i))) begin
          r_shadow[8*i +: 8] <= r_shift[7:0];
        end
      end
    end
  end

  // Pending flag: a commit in the same cycle as an apply must survive for the next strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending <= 1'b0;
    end else if (w_commit) begin
      r_pending <= 1'b1;
    end else if (w_apply) begin
      r_pending <= 1'b0;
    end
  end

  // Live config copies the whole shadow in one edge, so the datapath never sees a partial set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cfg       <= '0;
      r_cfg_upd   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_apply) begin
        r_cfg <= r_shadow;
      end
      r_cfg_upd   <= w_apply;
      r_frame_err <= w_err;
    end
  end

  assign bus.cfg_regs  = r_cfg;
  assign bus.cfg_upd   = r_cfg_upd;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule
